// File: rtl/nco_en_pkg.sv
// Shared types and helpers for the multi-channel NCO clock-enable generator.
// Channel FSM states, default widths and config validation.
package nco_en_pkg;

    localparam int DEF_ACC_W = 32;
    localparam int DEF_DIV_W = 4;
    // Validation is done at this width so any ACC_W up to 64 can be checked.
    localparam int MAX_ACC_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } ch_state_e;

    function automatic logic cfg_valid(input logic [MAX_ACC_W-1:0] step,
                                       input logic [MAX_ACC_W-1:0] period);
        return (period != '0) && (step < period);
    endfunction

endpackage

// File: rtl/nco_en_ch.sv
// One enable channel: IDLE/SETTLE/RUN FSM, phase accumulator, fixed-latency
// delay line and a divide-by-N secondary enable counted on en_out pulses.
module nco_en_ch
    import nco_en_pkg::*;
#(
    parameter int ACC_W      = DEF_ACC_W,
    parameter int DIV_W      = DEF_DIV_W,
    parameter int PIPE_DLY   = 8,
    parameter int SETTLE_CYC = 7
) (
    input  logic             sys_clk,
    input  logic             glb_rst_n,
    input  logic [ACC_W-1:0] cfg_step,
    input  logic [ACC_W-1:0] cfg_period,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_load,
    input  logic             ch_enable,
    output ch_state_e        state,
    output logic             cfg_err,
    output logic             en_out,
    output logic             en_div_out
);

    localparam int SUM_W       = ACC_W + 1;
    localparam int SET_W       = $clog2(SETTLE_CYC + 1);
    localparam int SETTLE_LAST = (SETTLE_CYC >= 2) ? SETTLE_CYC - 2 : 0;

    ch_state_e         state_d;
    logic [SET_W-1:0]  settle_cnt;
    logic [ACC_W-1:0]  step_q;
    logic [ACC_W-1:0]  period_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_cnt;
    logic [ACC_W-1:0]  phase;
    logic [ACC_W-1:0]  phase_d;
    logic [SUM_W-1:0]  sum;
    logic [PIPE_DLY-1:0] dly;
    logic [PIPE_DLY-1:0] dly_d;
    logic              load_ok;
    logic              acc_wrap;
    logic              div_hit;

    assign load_ok = cfg_valid(MAX_ACC_W'(cfg_step), MAX_ACC_W'(cfg_period));
    assign div_hit = (div_cnt == div_q - DIV_W'(1));

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:   state_d = ST_IDLE;
            ST_SETTLE: if (settle_cnt == SET_W'(SETTLE_LAST)) state_d = ST_RUN;
            ST_RUN:    state_d = ST_RUN;
            default:   state_d = ST_IDLE;
        endcase
        // A load overrides everything, from any state.
        if (cfg_load) begin
            if (!load_ok)             state_d = ST_IDLE;
            else if (SETTLE_CYC == 1) state_d = ST_RUN;
            else                      state_d = ST_SETTLE;
        end
    end

    // The sum is one bit wider than the operands so phase+step never overflows.
    always_comb begin
        sum      = SUM_W'(phase) + SUM_W'(step_q);
        acc_wrap = 1'b0;
        phase_d  = phase;
        if (state == ST_RUN && ch_enable) begin
            if (sum >= SUM_W'(period_q)) begin
                acc_wrap = 1'b1;
                phase_d  = ACC_W'(sum - SUM_W'(period_q));
            end else begin
                phase_d  = ACC_W'(sum);
            end
        end
        dly_d = (dly << 1) | PIPE_DLY'(acc_wrap);
    end

    always_ff @(posedge sys_clk or negedge glb_rst_n) begin
        if (!glb_rst_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            step_q     <= '0;
            period_q   <= '0;
            div_q      <= DIV_W'(1);
            div_cnt    <= '0;
            phase      <= '0;
            dly        <= '0;
            cfg_err    <= 1'b0;
            en_out     <= 1'b0;
            en_div_out <= 1'b0;
        end else begin
            state <= state_d;
            if (cfg_load) begin
                step_q     <= cfg_step;
                period_q   <= cfg_period;
                div_q      <= (cfg_div == '0) ? DIV_W'(1) : cfg_div;
                cfg_err    <= !load_ok;
                settle_cnt <= '0;
                phase      <= '0;
                dly        <= '0;
                div_cnt    <= '0;
                en_out     <= 1'b0;
                en_div_out <= 1'b0;
            end else begin
                settle_cnt <= (state == ST_SETTLE) ? settle_cnt + SET_W'(1) : '0;
                phase      <= phase_d;
                dly        <= dly_d;
                en_out     <= dly[PIPE_DLY-1];
                en_div_out <= dly[PIPE_DLY-1] && div_hit;
                if (dly[PIPE_DLY-1]) begin
                    div_cnt <= div_hit ? '0 : div_cnt + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/nco_en_gen_mc.sv
// Multi-channel fractional clock-enable generator: one independent NCO
// channel per slice of the packed configuration buses.
module nco_en_gen_mc
    import nco_en_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int PIPE_DLY   = 8,
    parameter int SETTLE_CYC = 7,
    parameter int DIV_W      = DEF_DIV_W
) (
    input  logic                    sys_clk,
    input  logic                    glb_rst_n,
    input  logic [NUM_CH*ACC_W-1:0] cfg_step,
    input  logic [NUM_CH*ACC_W-1:0] cfg_period,
    input  logic [NUM_CH*DIV_W-1:0] cfg_div,
    input  logic [NUM_CH-1:0]       cfg_load,
    input  logic [NUM_CH-1:0]       ch_enable,
    output logic [NUM_CH-1:0]       ch_running,
    output logic [NUM_CH-1:0]       cfg_err,
    output logic [NUM_CH-1:0]       en_out,
    output logic [NUM_CH-1:0]       en_div_out
);

    ch_state_e ch_state [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        nco_en_ch #(
            .ACC_W      (ACC_W),
            .DIV_W      (DIV_W),
            .PIPE_DLY   (PIPE_DLY),
            .SETTLE_CYC (SETTLE_CYC)
        ) u_ch (
            .sys_clk    (sys_clk),
            .glb_rst_n  (glb_rst_n),
            .cfg_step   (cfg_step[c*ACC_W +: ACC_W]),
            .cfg_period (cfg_period[c*ACC_W +: ACC_W]),
            .cfg_div    (cfg_div[c*DIV_W +: DIV_W]),
            .cfg_load   (cfg_load[c]),
            .ch_enable  (ch_enable[c]),
            .state      (ch_state[c]),
            .cfg_err    (cfg_err[c]),
            .en_out     (en_out[c]),
            .en_div_out (en_div_out[c])
        );

        assign ch_running[c] = (ch_state[c] == ST_RUN);
    end

endmodule

// File: tb/tb_nco_en_gen_mc.sv
// Directed bench for nco_en_gen_mc: pulse timing, fractional rate, config
// validation, divider, reload, per-channel enable and asynchronous reset.
module tb_nco_en_gen_mc;

    localparam int NUM_CH = 2;
    localparam int ACC_W  = 32;
    localparam int DIV_W  = 4;

    logic                    sys_clk = 1'b0;
    logic                    glb_rst_n;
    logic [NUM_CH*ACC_W-1:0] cfg_step;
    logic [NUM_CH*ACC_W-1:0] cfg_period;
    logic [NUM_CH*DIV_W-1:0] cfg_div;
    logic [NUM_CH-1:0]       cfg_load;
    logic [NUM_CH-1:0]       ch_enable;
    logic [NUM_CH-1:0]       ch_running;
    logic [NUM_CH-1:0]       cfg_err;
    logic [NUM_CH-1:0]       en_out;
    logic [NUM_CH-1:0]       en_div_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    nco_en_gen_mc #(
        .NUM_CH     (NUM_CH),
        .ACC_W      (ACC_W),
        .PIPE_DLY   (8),
        .SETTLE_CYC (7),
        .DIV_W      (DIV_W)
    ) dut (
        .sys_clk    (sys_clk),
        .glb_rst_n  (glb_rst_n),
        .cfg_step   (cfg_step),
        .cfg_period (cfg_period),
        .cfg_div    (cfg_div),
        .cfg_load   (cfg_load),
        .ch_enable  (ch_enable),
        .ch_running (ch_running),
        .cfg_err    (cfg_err),
        .en_out     (en_out),
        .en_div_out (en_div_out)
    );

    // Clock/edge helpers: samples and drives happen 1 ns after each rising edge.
    task automatic next_edge;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_cfg(input int c, input logic [ACC_W-1:0] step,
                           input logic [ACC_W-1:0] period, input logic [DIV_W-1:0] div);
        cfg_step[c*ACC_W +: ACC_W]   = step;
        cfg_period[c*ACC_W +: ACC_W] = period;
        cfg_div[c*DIV_W +: DIV_W]    = div;
    endtask

    // Pulses the given load mask across one edge (that edge is "edge 0").
    task automatic do_load(input logic [NUM_CH-1:0] mask);
        cfg_load = mask;
        next_edge();
        cfg_load = '0;
    endtask

    function automatic bit in_list(input int k, input int q[$]);
        foreach (q[i]) if (q[i] == k) return 1'b1;
        return 1'b0;
    endfunction

    task automatic test_reset;
        glb_rst_n = 1'b0;
        cfg_step = '0; cfg_period = '0; cfg_div = '0;
        cfg_load = '0; ch_enable = '0;
        #23;
        n_checks++;
        if ({ch_running, cfg_err, en_out, en_div_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0", {ch_running, cfg_err, en_out, en_div_out});
        end
        #4 glb_rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            next_edge();
            n_checks++;
            if ({ch_running, cfg_err, en_out, en_div_out} !== '0) begin
                n_fail++;
                $display("FAIL post_reset_idle edge %0d: got %b want 0", k, {ch_running, cfg_err, en_out, en_div_out});
            end
        end
    endtask

    // step/period = 1/2: pulse every 2nd cycle, first after edge 16.
    task automatic test_half_rate;
        logic exp_en;
        set_cfg(0, 32'd5000, 32'd10000, 4'd1);
        ch_enable = 2'b11;
        do_load(2'b01);
        for (int k = 1; k <= 30; k++) begin
            next_edge();
            exp_en = (k >= 16) && (k % 2 == 0);
            n_checks++;
            if (en_out[0] !== exp_en || en_div_out[0] !== exp_en || en_out[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL half_rate_en edge %0d: got en=%b div=%b want en0=%b div0=%b", k, en_out, en_div_out, exp_en, exp_en);
            end
            if (k <= 5 || k >= 7) begin
                n_checks++;
                if (ch_running[0] !== (k >= 7) || cfg_err[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL half_rate_running edge %0d: got run=%b err=%b want run=%b err=0", k, ch_running[0], cfg_err[0], k >= 7);
                end
            end
        end
    endtask

    // step/period = 3/10: wraps at RUN edges 4,7,10,14,17,20.
    task automatic test_fractional;
        int exp_q[$];
        logic exp_en;
        exp_q = '{18, 21, 24, 28, 31, 34};
        set_cfg(0, 32'd3, 32'd10, 4'd1);
        do_load(2'b01);
        for (int k = 1; k <= 36; k++) begin
            next_edge();
            exp_en = in_list(k, exp_q);
            n_checks++;
            if (en_out[0] !== exp_en) begin
                n_fail++;
                $display("FAIL frac_en edge %0d: got %b want %b", k, en_out[0], exp_en);
            end
        end
    endtask

    task automatic test_invalid;
        int exp_q[$];
        exp_q = '{18};
        for (int v = 0; v < 2; v++) begin
            if (v == 0) set_cfg(0, 32'd10, 32'd10, 4'd1);
            else        set_cfg(0, 32'd0, 32'd0, 4'd1);
            do_load(2'b01);
            for (int k = 1; k <= 12; k++) begin
                next_edge();
                n_checks++;
                if (cfg_err[0] !== 1'b1 || ch_running[0] !== 1'b0 || en_out[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL invalid_cfg%0d edge %0d: got err=%b run=%b en=%b want 1 0 0", v, k, cfg_err[0], ch_running[0], en_out[0]);
                end
            end
        end
        set_cfg(0, 32'd3, 32'd10, 4'd1);
        do_load(2'b01);
        for (int k = 1; k <= 18; k++) begin
            next_edge();
            n_checks++;
            if (cfg_err[0] !== 1'b0 || en_out[0] !== in_list(k, exp_q)) begin
                n_fail++;
                $display("FAIL valid_after_invalid edge %0d: got err=%b en=%b want 0 %b", k, cfg_err[0], en_out[0], in_list(k, exp_q));
            end
        end
    endtask

    // step/period = 1/4 with div 3, then reload mid-run with div 2.
    task automatic test_divider_reload;
        int en_q[$];
        int dv_q[$];
        en_q = '{18, 22, 26, 30, 34};
        dv_q = '{26};
        set_cfg(0, 32'd1, 32'd4, 4'd3);
        do_load(2'b01);
        for (int k = 1; k <= 34; k++) begin
            next_edge();
            n_checks++;
            if (en_out[0] !== in_list(k, en_q) || en_div_out[0] !== in_list(k, dv_q)) begin
                n_fail++;
                $display("FAIL div3 edge %0d: got en=%b div=%b want %b %b", k, en_out[0], en_div_out[0], in_list(k, en_q), in_list(k, dv_q));
            end
        end
        en_q = '{18, 22, 26, 30};
        dv_q = '{22, 30};
        set_cfg(0, 32'd1, 32'd4, 4'd2);
        do_load(2'b01);
        for (int k = 1; k <= 32; k++) begin
            next_edge();
            n_checks++;
            if (en_out[0] !== in_list(k, en_q) || en_div_out[0] !== in_list(k, dv_q)) begin
                n_fail++;
                $display("FAIL reload_div2 edge %0d: got en=%b div=%b want %b %b", k, en_out[0], en_div_out[0], in_list(k, en_q), in_list(k, dv_q));
            end
            if (k == 1) begin
                n_checks++;
                if (ch_running[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reload_settle: got run=%b want 0", ch_running[0]);
                end
            end
        end
    endtask

    // Both channels loaded together; ch1 disabled for edges 11..15.
    task automatic test_two_channels;
        int en1_q[$];
        logic exp0;
        logic exp1;
        en1_q = '{18, 27, 31, 35, 39};
        set_cfg(0, 32'd5000, 32'd10000, 4'd1);
        set_cfg(1, 32'd1, 32'd4, 4'd1);
        ch_enable = 2'b11;
        do_load(2'b11);
        for (int k = 1; k <= 40; k++) begin
            next_edge();
            exp0 = (k >= 16) && (k % 2 == 0);
            exp1 = in_list(k, en1_q);
            n_checks++;
            if (en_out !== {exp1, exp0} || en_div_out !== {exp1, exp0}) begin
                n_fail++;
                $display("FAIL two_ch edge %0d: got en=%b div=%b want %b", k, en_out, en_div_out, {exp1, exp0});
            end
            if (k >= 11 && k <= 15) begin
                n_checks++;
                if (ch_running !== 2'b11) begin
                    n_fail++;
                    $display("FAIL disabled_still_run edge %0d: got %b want 11", k, ch_running);
                end
            end
            if (k == 10) ch_enable[1] = 1'b0;
            if (k == 15) ch_enable[1] = 1'b1;
        end
    endtask

    task automatic test_async_reset;
        #3 glb_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ch_running, cfg_err, en_out, en_div_out} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_now: got %b want 0", {ch_running, cfg_err, en_out, en_div_out});
        end
        #2 glb_rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            next_edge();
            n_checks++;
            if ({ch_running, cfg_err, en_out, en_div_out} !== '0) begin
                n_fail++;
                $display("FAIL after_reset edge %0d: got %b want 0", k, {ch_running, cfg_err, en_out, en_div_out});
            end
        end
    endtask

    initial begin
        test_reset();
        test_half_rate();
        test_fractional();
        test_invalid();
        test_divider_reload();
        test_two_channels();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nco_en_gen_mc.md
Name: nco_en_gen_mc

Overview:
Multi-channel fractional clock-enable generator. Each channel is a phase-accumulator NCO that produces en pulses at an average rate of sys_clk*step/period. Each channel also has a synchronous divide-by-N secondary enable. It sits in the DVB-S2 datapath ahead of the TS/baseband framers and symbol-rate stages. It provides runtime reload, config validation, a fixed pipeline latency and per-channel enable control.

Parameters:
NUM_CH, 2, number of independent enable channels
ACC_W, 32, width of step, period and phase accumulator
PIPE_DLY, 8, sys_clk cycles from accumulator wrap to en_out (min 1)
SETTLE_CYC, 7, cycles held in SETTLE after a load before accumulation starts (min 1)
DIV_W, 4, width of per-channel secondary divide ratio

Ports:
sys_clk  in  1  system clock
glb_rst_n  in  1  asynchronous active-low reset
cfg_step  in  NUM_CH*ACC_W  per-channel phase increment (e.g. 2*baud_num); channel c at [c*ACC_W +: ACC_W]
cfg_period  in  NUM_CH*ACC_W  per-channel modulus (e.g. sys_freq_num)
cfg_div  in  NUM_CH*DIV_W  per-channel secondary divide ratio; 0 is treated as 1
cfg_load  in  NUM_CH  per-channel one-cycle load strobe; samples step/period/div
ch_enable  in  NUM_CH  level; 0 freezes the accumulator and suppresses outputs
ch_running  out  NUM_CH  channel is in RUN
cfg_err  out  NUM_CH  sticky; last load was invalid
en_out  out  NUM_CH  one-cycle enable pulses
en_div_out  out  NUM_CH  every cfg_div-th en_out pulse, coincident with it

Behaviour:
- Reset is asynchronous and active-low. All state clears: state=IDLE, phase=0, delay line=0, div count=0. All outputs are 0.
- Per-channel FSM with states IDLE, SETTLE, RUN:
  - IDLE: no pulses are generated. cfg_load with a valid config goes to SETTLE. An invalid load sets cfg_err and stays in IDLE.
  - Valid config: period!=0 and step<period. A valid load clears cfg_err.
  - SETTLE: phase is held at 0. The channel goes to RUN after SETTLE_CYC cycles.
  - RUN: at each edge where ch_enable=1, sum=phase+step is computed at ACC_W+1 bits, so no overflow occurs.
    - If sum>=period: phase<=sum-period and a wrap pulse is issued.
    - Otherwise phase<=sum.
  - RUN with ch_enable=0: phase is held and no wrap pulses are issued. Pulses already in the delay line drain normally.
  - cfg_load in any state, including RUN: re-sample, revalidate and restart at SETTLE with phase=0. The delay line and div count are flushed in the same cycle. An invalid reload goes to IDLE.
- Latency: a wrap at RUN edge n gives en_out high during the cycle after edge n+PIPE_DLY. The first RUN edge is SETTLE_CYC edges after the load edge.
- Pulse count: over any window of period RUN edges, exactly step wrap pulses occur. Maximum rate is one pulse per cycle; two pulses never merge.
- Divider:
  - Counts en_out pulses modulo cfg_div. en_div_out is asserted on the pulse where the pre-increment count==cfg_div-1.
  - The divider is fully synchronous to sys_clk; no derived clocks.
  - The first en_div_out after a load occurs on the cfg_div-th en_out.
- Channels are independent. Simultaneous loads on several channels are all honoured.
- ch_running is the registered state==RUN.

Decomposition:
- Package nco_en_pkg holds:
  - the state enum (IDLE/SETTLE/RUN)
  - localparam widths derived from ACC_W/DIV_W
  - a cfg validity function
- Sub-module nco_en_ch implements one channel: FSM, accumulator, delay line and divider. The top level generates NUM_CH instances and slices the packed buses.

Test Plan:
- step=5000, period=10000, div=1, ch_enable=1, load at edge 0:
  - RUN from edge 7.
  - en_out every 2nd cycle, first pulse after edge 16 (wrap at RUN edge 2 = edge 8, +PIPE_DLY).
  - en_div_out identical to en_out.
- step=3, period=10:
  - Wraps at RUN edges 4, 7, 10, 14, 17, 20, giving 3 pulses per 10 cycles.
  - Phase after a wrap takes the values 2, 1, 0 in turn.
- Invalid loads, step=10/period=10 and period=0:
  - cfg_err=1, ch_running=0, no en_out.
  - A following valid load clears cfg_err.
- div=3 with step=1, period=4:
  - en_out every 4 cycles.
  - en_div_out on the 3rd, 6th, ... en_out pulses.
  - Reload mid-run with div=2: in-flight pulses are dropped, SETTLE is re-entered, and the div count restarts.
- Two channels with different configs, plus ch_enable toggling:
  - Deassert for 5 cycles: no new wraps, pulse spacing shifts by exactly 5.
  - The other channel is unaffected.
- glb_rst_n asserted asynchronously mid-RUN, between edges:
  - All outputs go to 0 immediately.
  - After release, outputs stay at 0 until a new cfg_load.
